// File: rtl/instr_mem_bridge_pkg.sv
// Shared definitions for the instruction-memory bridge: FSM state encoding and
// wait-state counter width.
package instr_mem_bridge_pkg;

    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_e;

endpackage

// File: rtl/ibex_instr_bus.sv
// Ibex-style instruction fetch bus: req/addr from the core, gnt/rvalid/err/rdata back.
interface ibex_instr_bus;

    logic        req;
    logic [31:0] addr;
    logic        gnt;
    logic        rvalid;
    logic        err;
    logic [31:0] rdata;

    modport master (output req, addr, input gnt, rvalid, err, rdata);
    modport slave  (input req, addr, output gnt, rvalid, err, rdata);

endinterface

// File: rtl/instr_mem_bridge_decoder.sv
// Combinational address decode for instr_mem_bridge: byte address -> SRAM word address.
// Range check only with INSTR_MEM_BRIDGE_ADDR_CHECK_EN; otherwise every address is in range.
module instr_addr_decoder #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned MEM_WORDS = 4096
) (
    input  logic [31:0]                  i_addr,
    output logic [$clog2(MEM_WORDS)-1:0] o_word_addr,
    output logic                         o_in_range
);

    localparam int unsigned AW = $clog2(MEM_WORDS);

    logic [31:0] w_offset;
    logic        w_unused;

    // Modulo-2^32 offset: below-base addresses wrap to huge offsets and fail the check.
    assign w_offset    = i_addr - BASE_ADDR;
    assign o_word_addr = w_offset[AW+1:2];

`ifdef INSTR_MEM_BRIDGE_ADDR_CHECK_EN
    assign o_in_range = (w_offset[31:AW+2] == '0);
`else
    assign o_in_range = 1'b1;
`endif

    assign w_unused = ^{w_offset[1:0], w_offset[31:AW+2]};

endmodule

// File: rtl/instr_mem_bridge.sv
// Bridges an Ibex instruction fetch port to a synchronous-read instruction SRAM.
// Optional out-of-range error responses with INSTR_MEM_BRIDGE_ADDR_CHECK_EN.
module instr_mem_bridge
    import instr_mem_bridge_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned MEM_WORDS   = 4096,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    ibex_instr_bus.slave                 instr_bus,
    output logic                         mem_req,
    output logic [$clog2(MEM_WORDS)-1:0] mem_addr,
    input  logic [31:0]                  mem_rdata
);

    localparam logic [CNT_W-1:0] LAST_CNT =
        (WAIT_STATES == 0) ? '0 : CNT_W'(WAIT_STATES - 1);

    state_e                         r_state;
    logic [CNT_W-1:0]               r_cnt;
    logic                           r_err;
    logic                           w_gnt;
    logic                           w_rvalid;
    logic                           w_in_range;
    logic [$clog2(MEM_WORDS)-1:0]   w_word_addr;

    instr_addr_decoder #(
        .BASE_ADDR (BASE_ADDR),
        .MEM_WORDS (MEM_WORDS)
    ) u_dec (
        .i_addr      (instr_bus.addr),
        .o_word_addr (w_word_addr),
        .o_in_range  (w_in_range)
    );

    // Grant is combinational on req; gated by rst so it drops the moment reset asserts.
    always_comb begin
        w_gnt = 1'b0;
        if (!rst && instr_bus.req) begin
            case (r_state)
                IDLE, RESP: w_gnt = (WAIT_STATES == 0);
                WAIT:       w_gnt = (r_cnt == LAST_CNT);
                default:    w_gnt = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_err   <= 1'b0;
        end else if (w_gnt) begin
            r_state <= RESP;
            r_err   <= !w_in_range;
        end else begin
            case (r_state)
                IDLE, RESP: begin
                    r_state <= instr_bus.req ? WAIT : IDLE;
                    r_cnt   <= '0;
                end
                WAIT: begin
                    // A dropped req abandons the fetch without any response.
                    if (!instr_bus.req) begin
                        r_state <= IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign w_rvalid         = (r_state == RESP);
    assign mem_req          = w_gnt & w_in_range;
    assign mem_addr         = w_word_addr;
    assign instr_bus.gnt    = w_gnt;
    assign instr_bus.rvalid = w_rvalid;
    assign instr_bus.rdata  = (w_rvalid && !r_err) ? mem_rdata : '0;

`ifdef INSTR_MEM_BRIDGE_ADDR_CHECK_EN
    assign instr_bus.err = w_rvalid & r_err;
`else
    assign instr_bus.err = 1'b0;
`endif

endmodule

// File: tb/tb_instr_mem_bridge.sv
// Bench for instr_mem_bridge: one DUT with zero wait states, one with three,
// checked each cycle against a transaction-level reference model.
module tb_instr_mem_bridge;

    localparam logic [31:0] BASE = 32'h0001_0000;
    localparam int unsigned MW   = 4096;
`ifdef INSTR_MEM_BRIDGE_ADDR_CHECK_EN
    localparam bit CHECK = 1'b1;
`else
    localparam bit CHECK = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic [1:0]  tb_req;
    logic [31:0] tb_addr [2];
    logic [1:0]  w_gnt, w_rvalid, w_err, w_mem_req;
    logic [31:0] w_rdata [2];
    logic [11:0] w_mem_addr [2];
    logic [31:0] r_mem_rdata [2];
    logic [31:0] mem [MW];

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    // Reference model state: req cycles since last grant, and the pending response.
    int unsigned held   [2];
    logic        pend_v [2];
    logic        pend_e [2];
    logic [31:0] pend_d [2];

    ibex_instr_bus bus0 ();
    ibex_instr_bus bus1 ();

    assign bus0.req   = tb_req[0];
    assign bus0.addr  = tb_addr[0];
    assign bus1.req   = tb_req[1];
    assign bus1.addr  = tb_addr[1];
    assign w_gnt      = {bus1.gnt, bus0.gnt};
    assign w_rvalid   = {bus1.rvalid, bus0.rvalid};
    assign w_err      = {bus1.err, bus0.err};
    assign w_rdata[0] = bus0.rdata;
    assign w_rdata[1] = bus1.rdata;

    instr_mem_bridge #(
        .BASE_ADDR   (BASE),
        .MEM_WORDS   (MW),
        .WAIT_STATES (0)
    ) u_dut0 (
        .clk       (clk),
        .rst       (rst),
        .instr_bus (bus0.slave),
        .mem_req   (w_mem_req[0]),
        .mem_addr  (w_mem_addr[0]),
        .mem_rdata (r_mem_rdata[0])
    );

    instr_mem_bridge #(
        .BASE_ADDR   (BASE),
        .MEM_WORDS   (MW),
        .WAIT_STATES (3)
    ) u_dut1 (
        .clk       (clk),
        .rst       (rst),
        .instr_bus (bus1.slave),
        .mem_req   (w_mem_req[1]),
        .mem_addr  (w_mem_addr[1]),
        .mem_rdata (r_mem_rdata[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (w_mem_req[0]) r_mem_rdata[0] <= mem[w_mem_addr[0]];
        if (w_mem_req[1]) r_mem_rdata[1] <= mem[w_mem_addr[1]];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int unsigned ws(input bit d);
        return d ? 3 : 0;
    endfunction

    function automatic logic in_rng(input logic [31:0] a);
        return !CHECK || ((a >= BASE) && (a < BASE + 4 * MW));
    endfunction

    function automatic logic [11:0] word_of(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        return 12'((off / 4) % MW);
    endfunction

    function automatic logic [31:0] memw(input int unsigned k);
        return mem[12'(k)];
    endfunction

    function automatic logic [31:0] pick_addr();
        int unsigned r;
        r = $urandom_range(0, 99);
        if (r < 80) return BASE + ($urandom_range(0, MW - 1) << 2) + $urandom_range(0, 3);
        if (r < 90) return BASE + 4 * MW + ($urandom_range(0, 1023) << 2);
        return BASE - ($urandom_range(1, 256) << 2);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic drive(input bit d, input logic req, input logic [31:0] addr);
        tb_req[d]  = req;
        tb_addr[d] = addr;
    endtask

    task automatic monitor(input bit d);
        logic       eg;
        logic       inr;
        if (rst) begin
            chk($sformatf("rst_gnt%0d", d),     32'(w_gnt[d]),     0);
            chk($sformatf("rst_rvalid%0d", d),  32'(w_rvalid[d]),  0);
            chk($sformatf("rst_err%0d", d),     32'(w_err[d]),     0);
            chk($sformatf("rst_memreq%0d", d),  32'(w_mem_req[d]), 0);
            held[d]   = 0;
            pend_v[d] = 1'b0;
            pend_e[d] = 1'b0;
            pend_d[d] = '0;
        end else begin
            eg  = tb_req[d] && (held[d] == ws(d));
            inr = in_rng(tb_addr[d]);
            chk($sformatf("gnt%0d", d),    32'(w_gnt[d]),     32'(eg));
            chk($sformatf("rvalid%0d", d), 32'(w_rvalid[d]),  32'(pend_v[d]));
            chk($sformatf("err%0d", d),    32'(w_err[d]),     32'(pend_e[d]));
            chk($sformatf("rdata%0d", d),  w_rdata[d],        pend_v[d] ? pend_d[d] : 32'h0);
            chk($sformatf("memreq%0d", d), 32'(w_mem_req[d]), 32'(eg && inr));
            if (eg && inr)
                chk($sformatf("memaddr%0d", d), 32'(w_mem_addr[d]), 32'(word_of(tb_addr[d])));
            if (eg) begin
                pend_v[d] = 1'b1;
                pend_e[d] = !inr;
                pend_d[d] = inr ? mem[word_of(tb_addr[d])] : 32'h0;
                held[d]   = 0;
            end else begin
                pend_v[d] = 1'b0;
                pend_e[d] = 1'b0;
                held[d]   = tb_req[d] ? held[d] + 1 : 0;
            end
        end
    endtask

    always @(negedge clk) begin
        monitor(1'b0);
        monitor(1'b1);
    end

    task automatic rand_traffic(input bit d, input int unsigned n);
        logic        granted;
        logic        aborted;
        int unsigned waited;
        for (int unsigned i = 0; i < n; i++) begin
            drive(d, 1'b1, pick_addr());
            granted = 1'b0;
            aborted = 1'b0;
            waited  = 0;
            while (!granted && !aborted && waited < 40) begin
                mid();
                granted = w_gnt[d];
                step();
                waited++;
                if (!granted && $urandom_range(0, 19) == 0) aborted = 1'b1;
            end
            chk($sformatf("gnt_bound%0d", d), 32'(granted || aborted), 1);
            if (aborted || $urandom_range(0, 1) == 0) begin
                tb_req[d] = 1'b0;
                repeat ($urandom_range(1, 2)) step();
            end
        end
        tb_req[d] = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < MW; i++) mem[12'(i)] = $urandom;
        rst    = 1'b1;
        tb_req = '0;
        drive(1'b0, 1'b0, BASE);
        drive(1'b1, 1'b0, BASE);
        repeat (3) step();
        rst = 1'b0;
        mid();
        chk("idle_gnt",    32'(w_gnt),     0);
        chk("idle_rvalid", 32'(w_rvalid),  0);
        chk("idle_memreq", 32'(w_mem_req), 0);

        // Zero wait states: three back-to-back fetches, one per cycle.
        for (int unsigned k = 0; k < 3; k++) begin
            step();
            drive(1'b0, 1'b1, BASE + 4 * k);
            mid();
            chk("b2b_gnt", 32'(w_gnt[0]), 1);
            chk("b2b_memaddr", 32'(w_mem_addr[0]), k);
            if (k > 0) begin
                chk("b2b_rvalid", 32'(w_rvalid[0]), 1);
                chk("b2b_rdata", w_rdata[0], memw(k - 1));
            end
        end
        step();
        drive(1'b0, 1'b0, BASE);
        mid();
        chk("b2b_last_rvalid", 32'(w_rvalid[0]), 1);
        chk("b2b_last_rdata", w_rdata[0], memw(2));
        step();
        mid();
        chk("b2b_done_rvalid", 32'(w_rvalid[0]), 0);

        // Three wait states: grant on the 4th cycle of req.
        step();
        drive(1'b1, 1'b1, BASE + 32'h10);
        for (int unsigned c = 1; c <= 4; c++) begin
            mid();
            chk("ws3_gnt", 32'(w_gnt[1]), (c == 4) ? 1 : 0);
            if (c < 4) step();
        end
        chk("ws3_memaddr", 32'(w_mem_addr[1]), 4);
        chk("ws3_memreq", 32'(w_mem_req[1]), 1);
        step();
        drive(1'b1, 1'b0, BASE);
        mid();
        chk("ws3_rvalid", 32'(w_rvalid[1]), 1);
        chk("ws3_rdata", w_rdata[1], memw(4));
        step();
        mid();
        chk("ws3_rvalid_once", 32'(w_rvalid[1]), 0);

        // Just past the end of memory.
        step();
        drive(1'b0, 1'b1, BASE + 32'h4000);
        mid();
        chk("oor_gnt", 32'(w_gnt[0]), 1);
        chk("oor_memreq", 32'(w_mem_req[0]), CHECK ? 0 : 1);
        if (!CHECK) chk("oor_memaddr", 32'(w_mem_addr[0]), 0);
        step();
        drive(1'b0, 1'b0, BASE);
        mid();
        chk("oor_rvalid", 32'(w_rvalid[0]), 1);
        chk("oor_err", 32'(w_err[0]), CHECK ? 1 : 0);
        chk("oor_rdata", w_rdata[0], CHECK ? 32'h0 : memw(0));

        // Byte offset 3 within word 2 behaves like the aligned address.
        step();
        drive(1'b0, 1'b1, BASE + 32'h0B);
        mid();
        chk("mis_gnt", 32'(w_gnt[0]), 1);
        chk("mis_memaddr", 32'(w_mem_addr[0]), 2);
        step();
        drive(1'b0, 1'b0, BASE);
        mid();
        chk("mis_rvalid", 32'(w_rvalid[0]), 1);
        chk("mis_err", 32'(w_err[0]), 0);
        chk("mis_rdata", w_rdata[0], memw(2));

        // Reset during a response (DUT1) and during a grant (DUT0).
        step();
        drive(1'b1, 1'b1, BASE + 32'h20);
        repeat (3) begin
            mid();
            step();
        end
        mid();
        chk("rstseq_gnt1", 32'(w_gnt[1]), 1);
        step();
        drive(1'b1, 1'b0, BASE);
        drive(1'b0, 1'b1, BASE + 32'h30);
        #1;
        chk("rstseq_resp1", 32'(w_rvalid[1]), 1);
        chk("rstseq_gnt0", 32'(w_gnt[0]), 1);
        #1;
        rst = 1'b1;
        #1;
        chk("async_rvalid1", 32'(w_rvalid[1]), 0);
        chk("async_err1", 32'(w_err[1]), 0);
        chk("async_gnt0", 32'(w_gnt[0]), 0);
        chk("async_memreq0", 32'(w_mem_req[0]), 0);
        step();
        rst = 1'b0;
        mid();
        chk("post_rst_rvalid1", 32'(w_rvalid[1]), 0);
        chk("post_rst_rvalid0", 32'(w_rvalid[0]), 0);
        chk("post_rst_gnt0", 32'(w_gnt[0]), 1);
        chk("post_rst_memaddr0", 32'(w_mem_addr[0]), 12);
        step();
        drive(1'b0, 1'b0, BASE);
        mid();
        chk("post_rst_resp0", 32'(w_rvalid[0]), 1);
        chk("post_rst_rdata0", w_rdata[0], memw(12));

        step();
        rand_traffic(1'b0, 150);
        rand_traffic(1'b1, 60);
        repeat (3) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1);
    end

endmodule

// File: doc/instr_mem_bridge.md
INSTR_MEM_BRIDGE -- requirements
Module: instr_mem_bridge

Interface
REQ-001 The block SHALL have parameter BASE_ADDR, default 32'h0000_0000, meaning the byte address of memory word 0.
REQ-002 The block SHALL have parameter MEM_WORDS, default 4096, meaning memory depth in 32-bit words (power of two).
REQ-003 The block SHALL have parameter WAIT_STATES, default 0, range 0..15, meaning cycles of held req before gnt.
REQ-004 The block SHALL have port clk, input, 1 bit, the single clock; all logic on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit, reset, asynchronous and active-high.
REQ-006 The block SHALL have port instr_bus, ibex_instr_bus.slave modport, carrying req/addr in and gnt/rvalid/err/rdata out.
REQ-007 The block SHALL have port mem_req, output, 1 bit, synchronous-read strobe to instruction SRAM.
REQ-008 The block SHALL have port mem_addr, output, $clog2(MEM_WORDS) bits, SRAM word address.
REQ-009 The block SHALL have port mem_rdata, input, 32 bits, SRAM read data, valid the cycle after mem_req.

Function
REQ-010 The FSM SHALL have states IDLE, WAIT and RESP.
REQ-011 IDLE with req=1 SHALL grant in the same cycle when WAIT_STATES=0, else go to WAIT with the counter cleared.
REQ-012 WAIT SHALL increment the counter each cycle req=1 and assert gnt combinationally when counter==WAIT_STATES-1.
REQ-013 req dropping in WAIT (not Ibex-legal) SHALL return the FSM to IDLE with no grant and no response.
REQ-014 On a grant (req&gnt), the FSM SHALL enter RESP; in RESP, rvalid=1 for exactly one cycle.
REQ-015 In-range grant: mem_req=1 in the grant cycle, mem_addr=(addr-BASE_ADDR)>>2, addr[1:0] ignored.
REQ-016 In RESP after in-range grant: rdata=mem_rdata, err=0.
REQ-017 In RESP with WAIT_STATES=0 and req=1, the block SHALL grant again that cycle to give one fetch per cycle sustained; otherwise it returns to IDLE, or to WAIT if req=1.
REQ-018 At most one outstanding transaction SHALL exist; gnt SHALL never assert while a granted response is not yet returned.
REQ-019 gnt, rvalid, err and mem_req SHALL be 0 whenever not explicitly asserted above; rdata SHALL be 0 when rvalid=0.

Reset
REQ-020 On rst assertion the FSM SHALL enter IDLE, clear the counter and the error flag, and drive gnt/rvalid/err/mem_req=0 immediately (asynchronous).
REQ-021 A grant interrupted by rst SHALL produce no rvalid after release; first grant possible in the first cycle after rst deasserts.

Configuration
REQ-022 With macro INSTR_MEM_BRIDGE_ADDR_CHECK_EN defined, an address outside [BASE_ADDR, BASE_ADDR+4*MEM_WORDS) SHALL be granted with mem_req=0 and answered next cycle by rvalid=1, err=1, rdata=0.
REQ-023 Without INSTR_MEM_BRIDGE_ADDR_CHECK_EN, err SHALL be tied 0 and every address maps to mem_addr=((addr-BASE_ADDR)>>2) modulo MEM_WORDS.

Structure
REQ-024 Shared package instr_mem_bridge_pkg SHALL hold the FSM state enum and the WAIT_STATES counter width constant (4).
REQ-025 Address decode/range check SHALL be a sub-module instr_addr_decoder (combinational: addr in -> word address, in_range out); no other sub-modules.

Verification
REQ-026 WAIT_STATES=0: req held for addresses BASE+0, +4, +8 -> gnt in each cycle, rvalid in three consecutive cycles with matching SRAM words.
REQ-027 WAIT_STATES=3: single req at BASE+0x10 -> gnt on 4th cycle of req, mem_addr=4, rvalid exactly one cycle later.
REQ-028 ADDR_CHECK_EN, MEM_WORDS=4096, req at BASE+0x4000 -> gnt, mem_req=0, next cycle rvalid=1, err=1, rdata=0.
REQ-029 Without macro, same address -> mem_addr=0, err=0, rdata=SRAM word 0.
REQ-030 rst asserted in RESP cycle -> rvalid falls to 0 asynchronously; after release idle with all outputs 0 until next req.
REQ-031 addr[1:0]=2'b11 at BASE+0x0B -> mem_addr=2, response identical to a request at BASE+0x08.
